// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared state encodings, PS/2 header bit positions and
//                delta saturation helper for the PS/2 packet framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // UART byte receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Packet framer states; GOTn means byte n of the packet has been taken
    typedef enum logic [1:0] {
        FR_IDLE = 2'd0,
        FR_GOT0 = 2'd1,
        FR_GOT1 = 2'd2
    } fr_state_t;

    // Header (byte 0) bit positions
    localparam int SYNC = 3;
    localparam int XS   = 4;
    localparam int YS   = 5;
    localparam int XO   = 6;
    localparam int YO   = 7;

    // Saturated delta values used when the overflow bit is set
    localparam logic [8:0] SAT_POS = 9'h0FF;
    localparam logic [8:0] SAT_NEG = 9'h100;

    // Build a 9-bit two's-complement delta from the header sign/overflow bits
    function automatic logic [8:0] ps2_delta(input logic sign,
                                             input logic ovf,
                                             input logic [7:0] mag);
        logic [8:0] v;
        v = {sign, mag};
        if (ovf) begin
            v = sign ? SAT_NEG : SAT_POS;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_rx
//  Description : 8N1 UART byte receiver with 2-FF input synchroniser,
//                start-bit glitch rejection and stop-bit frame checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_rx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_strobe,
    output logic       frame_err
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] C_DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(HALF - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    rx_state_t       r_state;
    rx_state_t       w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_byte_strobe;
    logic            r_frame_err;
    logic            w_tick;
    logic            w_take_bit;
    logic            w_stop_ok;
    logic            w_stop_bad;

    // Synchronise the serial line and keep one delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Next-state logic and sample strobes; start bit is sampled at half a bit
    always_comb begin
        w_state_next = r_state;
        w_tick       = (r_state == RX_START) ? (r_cnt == C_HALF_LAST)
                                             : (r_cnt == C_DIV_LAST);
        w_take_bit   = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_prev && !r_sync2) w_state_next = RX_START;
            end
            RX_START: begin
                if (w_tick) w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_tick) begin
                    w_take_bit = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick) begin
                    w_stop_ok    = r_sync2;
                    w_stop_bad   = !r_sync2;
                    w_state_next = RX_IDLE;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // State register, bit timer, shift register and output strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= RX_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'd0;
            r_byte_strobe <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_tick || r_state == RX_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == RX_START) begin
                r_bit_idx <= 3'd0;
            end else if (w_take_bit) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_take_bit) begin
                r_shift <= {r_sync2, r_shift[7:1]};
            end
            r_byte_strobe <= w_stop_ok;
            r_frame_err   <= w_stop_bad;
        end
    end

    assign byte_data   = r_shift;
    assign byte_strobe = r_byte_strobe;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_packet_framer.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_packet_framer
//  Description : Receives UART-carried PS/2 mouse bytes, frames 3-byte
//                packets and emits saturated 9-bit deltas plus buttons.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_packet_framer
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ       = 25000000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [2:0] btn,
    output logic       packet_valid,
    output logic       error_flag,
    output logic       activity
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]  w_byte_data;
    logic        w_byte_strobe;
    logic        w_frame_err;
    fr_state_t   r_state;
    fr_state_t   w_state_next;
    logic [TW-1:0] r_tmo;
    logic [2:0]  r_hdr_btn;
    logic        r_xs;
    logic        r_ys;
    logic        r_xo;
    logic        r_yo;
    logic [7:0]  r_x;
    logic        w_latch_hdr;
    logic        w_latch_x;
    logic        w_done;
    logic        w_err_set;
    logic        w_timeout;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (uart_rx),
        .byte_data   (w_byte_data),
        .byte_strobe (w_byte_strobe),
        .frame_err   (w_frame_err)
    );

    // Framer next-state: frame errors dominate, then bytes, then timeout
    always_comb begin
        w_state_next = r_state;
        w_latch_hdr  = 1'b0;
        w_latch_x    = 1'b0;
        w_done       = 1'b0;
        w_err_set    = 1'b0;
        w_timeout    = (r_state != FR_IDLE) && (r_tmo == C_TMO_LAST);
        if (w_frame_err) begin
            w_state_next = FR_IDLE;
            w_err_set    = 1'b1;
        end else if (w_byte_strobe) begin
            case (r_state)
                FR_IDLE: begin
                    if (w_byte_data[SYNC]) begin
                        w_latch_hdr  = 1'b1;
                        w_state_next = FR_GOT0;
                    end else begin
                        w_err_set    = 1'b1;
                    end
                end
                FR_GOT0: begin
                    w_latch_x    = 1'b1;
                    w_state_next = FR_GOT1;
                end
                FR_GOT1: begin
                    w_done       = 1'b1;
                    w_state_next = FR_IDLE;
                end
                default: w_state_next = FR_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_next = FR_IDLE;
            w_err_set    = 1'b1;
        end
    end

    // Framer state, inter-byte timer and partial packet storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FR_IDLE;
            r_tmo     <= '0;
            r_hdr_btn <= 3'd0;
            r_xs      <= 1'b0;
            r_ys      <= 1'b0;
            r_xo      <= 1'b0;
            r_yo      <= 1'b0;
            r_x       <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_byte_strobe || r_state == FR_IDLE) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (w_latch_hdr) begin
                r_hdr_btn <= w_byte_data[2:0];
                r_xs      <= w_byte_data[XS];
                r_ys      <= w_byte_data[YS];
                r_xo      <= w_byte_data[XO];
                r_yo      <= w_byte_data[YO];
            end
            if (w_latch_x) begin
                r_x <= w_byte_data;
            end
        end
    end

    // Output assembly; an error set in the same cycle wins over the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx           <= 9'd0;
            dy           <= 9'd0;
            btn          <= 3'd0;
            packet_valid <= 1'b0;
            error_flag   <= 1'b0;
            activity     <= 1'b0;
        end else begin
            packet_valid <= w_done;
            if (w_done) begin
                dx       <= ps2_delta(r_xs, r_xo, r_x);
                dy       <= ps2_delta(r_ys, r_yo, w_byte_data);
                btn      <= r_hdr_btn;
                activity <= ~activity;
            end
            if (w_err_set) begin
                error_flag <= 1'b1;
            end else if (w_done) begin
                error_flag <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_packet_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_packet_framer
//  Description : Self-checking bench for ps2_packet_framer with a packet-level
//                reference model and randomized byte streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_packet_framer;

    localparam int CLK_FREQ = 25_000_000;
    localparam int BAUD     = 1_562_500;
    localparam int TMO      = 2000;
    localparam int DIV      = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [2:0] btn;
    logic       packet_valid;
    logic       error_flag;
    logic       activity;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  pend[$];
    logic [20:0] exp_q[$];
    logic [20:0] got_q[$];
    bit          exp_err = 1'b0;
    bit          exp_act = 1'b0;

    ps2_packet_framer #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD           (BAUD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx      (uart_rx),
        .dx           (dx),
        .dy           (dy),
        .btn          (btn),
        .packet_valid (packet_valid),
        .error_flag   (error_flag),
        .activity     (activity)
    );

    always #5 clk = ~clk;

    // Capture every strobed packet away from the active edge
    always @(negedge clk) begin
        if (reset === 1'b0 && packet_valid === 1'b1) got_q.push_back({dx, dy, btn});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Signed value of a movement byte, then saturated, then reduced to 9 bits
    function automatic logic [8:0] ref_delta(input bit sign, input bit ovf, input logic [7:0] b);
        int v;
        v = sign ? int'(b) - 256 : int'(b);
        if (ovf) v = sign ? -256 : 255;
        return 9'(v);
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [7:0] h;
        if (!ok) begin
            pend.delete();
            exp_err = 1'b1;
        end else if (pend.size() == 0 && !b[3]) begin
            exp_err = 1'b1;
        end else begin
            pend.push_back(b);
            if (pend.size() == 3) begin
                h = pend[0];
                exp_q.push_back({ref_delta(h[4], h[6], pend[1]),
                                 ref_delta(h[5], h[7], pend[2]), h[2:0]});
                pend.delete();
                exp_err = 1'b0;
                exp_act = ~exp_act;
            end
        end
    endtask

    task automatic compare_state(input string tag);
        logic [20:0] g;
        logic [20:0] e;
        check({tag, "_pkt_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_dx"},  g[20:12], e[20:12]);
            check({tag, "_dy"},  g[11:3],  e[11:3]);
            check({tag, "_btn"}, g[2:0],   e[2:0]);
        end
        got_q.delete();
        exp_q.delete();
        check({tag, "_error_flag"}, error_flag, exp_err);
        check({tag, "_activity"},   activity,   exp_act);
    endtask

    task automatic drive_bit(input logic v);
        uart_rx = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input bit ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(ok);
        drive_bit(1'b1);
        model_byte(b, ok);
        compare_state(tag);
    endtask

    task automatic send_pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
        send_byte(tag, b0, 1'b1);
        send_byte(tag, b1, 1'b1);
        send_byte(tag, b2, 1'b1);
    endtask

    task automatic idle_timeout(input string tag);
        repeat (TMO + 10) @(negedge clk);
        if (pend.size() > 0) begin
            pend.delete();
            exp_err = 1'b1;
        end
        compare_state(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        int         r;

        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_dx", dx, 0);
        check("rst_pv", packet_valid, 0);
        check("rst_err", error_flag, 0);
        check("rst_act", activity, 0);
        reset = 1'b0;
        repeat (4 * DIV) @(negedge clk);

        // Put nonzero values on every output, then reset in the middle of a byte
        send_pkt("pre", 8'h1F, 8'h22, 8'h44);
        send_byte("pre_bad", 8'h05, 1'b1);
        uart_rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_dx", dx, 0);
        check("async_dy", dy, 0);
        check("async_btn", btn, 0);
        check("async_pv", packet_valid, 0);
        check("async_err", error_flag, 0);
        check("async_act", activity, 0);
        pend.delete();
        exp_err = 1'b0;
        exp_act = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        got_q.delete();
        repeat (12 * DIV) @(negedge clk);

        send_pkt("clean", 8'h08, 8'h05, 8'h03);
        check("clean_dx", dx, 9'h005);
        check("clean_dy", dy, 9'h003);

        send_pkt("sign", 8'h39, 8'hFB, 8'h02);
        check("sign_dx", dx, 9'h1FB);
        check("sign_dy", dy, 9'h102);
        check("sign_btn", btn, 3'b001);

        send_pkt("xovf", 8'h58, 8'h10, 8'h00);
        check("xovf_dx", dx, 9'h100);
        send_pkt("yovf", 8'h98, 8'h00, 8'h00);
        check("yovf_dy", dy, 9'h0FF);
        send_pkt("xovf_pos", 8'h48, 8'h80, 8'h01);
        check("xovf_pos_dx", dx, 9'h0FF);

        send_byte("resync_bad", 8'h05, 1'b1);
        check("resync_err_set", error_flag, 1);
        send_pkt("resync", 8'h08, 8'h01, 8'h01);
        check("resync_err_clr", error_flag, 0);

        send_byte("tmo_h", 8'h08, 1'b1);
        send_byte("tmo_x", 8'h01, 1'b1);
        idle_timeout("tmo");
        check("tmo_err", error_flag, 1);
        send_pkt("after_tmo", 8'h08, 8'h02, 8'h03);
        check("after_tmo_dx", dx, 9'h002);
        check("after_tmo_dy", dy, 9'h003);

        send_byte("frm_h", 8'h08, 1'b1);
        send_byte("frm_x", 8'h07, 1'b1);
        send_byte("frm_bad", 8'h09, 1'b0);
        check("frm_err", error_flag, 1);
        send_pkt("after_frm", 8'h0A, 8'h11, 8'h22);

        // Short low pulse must be rejected as a start-bit glitch
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        compare_state("glitch");

        for (int k = 0; k < 30; k++) begin
            r  = $urandom_range(0, 9);
            b0 = 8'($urandom) | 8'h08;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            if (r < 7) begin
                send_pkt("rnd_pkt", b0, b1, b2);
            end else if (r == 7) begin
                send_byte("rnd_lone", b1 & 8'hF7, 1'b1);
            end else if (r == 8) begin
                send_byte("rnd_fe_h", b0, 1'b1);
                send_byte("rnd_fe", b1, 1'b0);
            end else begin
                send_byte("rnd_to_h", b0, 1'b1);
                send_byte("rnd_to_x", b1, 1'b1);
                idle_timeout("rnd_to");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
